// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional madd/maddu accumulate support is compiled in with `define MDU_MADD_EN.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dbg_state_o
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic        rs_neg, rt_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
    logic        long_op, accept;

    assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign rs_neg = (op == 3'd2) && rs_data[31];
    assign rt_neg = (op == 3'd2) && rt_data[31];
    assign a_mag  = rs_neg ? (32'd0 - rs_data) : rs_data;
    assign b_mag  = rt_neg ? (32'd0 - rt_data) : rt_data;
    assign b_safe = (rt_data == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = rs_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        long_op = 1'b0;
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: long_op = 1'b1;
`ifdef MDU_MADD_EN
            3'd6, 3'd7:             long_op = 1'b1;
`endif
            default:                long_op = 1'b0;
        endcase
    end

    assign accept      = start && !cancel && (state_q == S_IDLE);
    assign busy        = (state_q == S_RUN);
    assign stall       = busy || (start && !cancel && long_op);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = (state_q == S_RUN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        3'd0, 3'd1: begin
                            pend_d    = (op == 3'd0) ? prod_s : prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = 4'(MULT_CYCLES);
                            state_d   = S_RUN;
                        end
                        3'd2, 3'd3: begin
                            // Divide by zero still runs the full latency but never commits.
                            pend_d    = {rem, quo};
                            pend_wr_d = (rt_data != 32'd0);
                            cnt_d     = 4'(DIV_CYCLES);
                            state_d   = S_RUN;
                        end
                        3'd4: hi_d = rs_data;
                        3'd5: lo_d = rs_data;
`ifdef MDU_MADD_EN
                        3'd6, 3'd7: begin
                            pend_d    = {hi_q, lo_q} + ((op == 3'd6) ? prod_s : prod_u);
                            pend_wr_d = 1'b1;
                            cnt_d     = 4'(MULT_CYCLES);
                            state_d   = S_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: arithmetic reference model, per-cycle compare, directed and random stimulus.
module tb_mdu_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, reset, start, cancel;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        busy, stall, dbg_state;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .stall(stall),
        .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_long(input logic [2:0] o);
`ifdef MDU_MADD_EN
        return o != 3'd4 && o != 3'd5;
`else
        return o <= 3'd3;
`endif
    endfunction

    // Reference arithmetic: bit 64 = commit enable, [63:32]=hi, [31:0]=lo.
    function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: p = 64'(sa * sb);
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) return {1'b0, 64'd0};
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {1'b0, 64'd0};
                return {1'b1, a % b, a / b};
            end
            3'd6: p = {h, l} + 64'(sa * sb);
            default: p = {h, l} + {32'd0, a} * {32'd0, b};
        endcase
        return {1'b1, p};
    endfunction

    // behavioural model
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic [64:0] exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_left <= 0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                if (exp_q[0][64]) begin
                    m_hi <= exp_q[0][63:32];
                    m_lo <= exp_q[0][31:0];
                end
                void'(exp_q.pop_front());
            end
        end else if (start && !cancel) begin
            if (op == 3'd4) m_hi <= rs_data;
            else if (op == 3'd5) m_lo <= rs_data;
            else if (is_long(op)) begin
                exp_q.push_back(ref_result(op, rs_data, rt_data, m_hi, m_lo));
                m_left <= (op == 3'd2 || op == 3'd3) ? DC : MC;
            end
        end
    end

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy",  64'(busy),  64'(m_left != 0));
            chk("dbg",   64'(dbg_state), 64'(m_left != 0));
            chk("stall", 64'(stall), 64'((m_left != 0) || (start && !cancel && is_long(op))));
            chk("hi",    64'(hi),    64'(m_hi));
            chk("lo",    64'(lo),    64'(m_lo));
        end
    end

    // driver tasks
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        start = 1'b1; op = o; rs_data = a; rt_data = b; cancel = c;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("busy_timeout", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0;
        rs_data = 32'd0; rt_data = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);

        // mult -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_hold_lo", 64'(lo), 64'd0);
        busy_len(n);
        chk("mult_busy_len", 64'(n), 64'(MC));
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);

        // div -7 / 2, then divu by zero
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        busy_len(n);
        chk("div_busy_len", 64'(n), 64'(DC));
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd0, 1'b0);
        busy_len(n);
        chk("div0_busy_len", 64'(n), 64'(DC));
        chk("div0_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div0_hi", 64'(hi), 64'hFFFF_FFFF);

        // signed overflow divide
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        busy_len(n);
        chk("divovf_lo", 64'(lo), 64'h8000_0000);
        chk("divovf_hi", 64'(hi), 64'd0);

        // mthi then mtlo back to back
        issue(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi", 64'(hi), 64'h1234_5678);
        chk("mthi_nobusy", 64'(busy), 64'd0);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
        chk("mtlo", 64'(lo), 64'h9ABC_DEF0);
        chk("mtlo_keep_hi", 64'(hi), 64'h1234_5678);

        // cancelled start
        issue(3'd0, 32'd9, 32'd9, 1'b1);
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_lo", 64'(lo), 64'h9ABC_DEF0);

        // back-to-back with an ignored start during busy
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        busy_len(n);
        chk("b2b_busy_len", 64'(n + 1), 64'(MC));
        chk("b2b_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("b2b_lo", 64'(lo), 64'h0000_0001);
        issue(3'd0, 32'd3, 32'd4, 1'b0);
        chk("b2b_accept", 64'(busy), 64'd1);
        busy_len(n);
        chk("b2b2_lo", 64'(lo), 64'd12);
        chk("b2b2_hi", 64'(hi), 64'd0);

        // madd accumulate carry
        issue(3'd4, 32'd0, 32'd0, 1'b0);
        issue(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(3'd6, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        chk("madd_busy", 64'(busy), 64'd1);
        busy_len(n);
        chk("madd_len", 64'(n), 64'(MC));
        chk("madd_hi", 64'(hi), 64'd1);
        chk("madd_lo", 64'(lo), 64'd0);
`else
        chk("madd_busy", 64'(busy), 64'd0);
        chk("madd_hi", 64'(hi), 64'd0);
        chk("madd_lo", 64'(lo), 64'hFFFF_FFFF);
`endif

        // asynchronous reset in the middle of a divide
        issue(3'd4, 32'hAAAA_5555, 32'd0, 1'b0);
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("arst_after_busy", 64'(busy), 64'd0);

        // randomized traffic, including starts during busy and cancels
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0)
                issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
                      ($urandom_range(0, 7) == 0));
            else begin
                @(posedge clk); #1;
            end
        end
        busy_len(n);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the architectural HI/LO registers; executes mult/multu/div/divu/mthi/mtlo.
- Exposes HI/LO so mfhi/mflo results travel down the pipeline to the register file writeback.
- Provides busy/stall to the hazard unit so later HI/LO users wait for the result.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy duration in cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle request, qualified by op; sampled at rising edge.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6=madd, 7=maddu.
- cancel  input  1  exception/interrupt flush from the CP0 path; suppresses a start in the same cycle.
- rs_data  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_data  input  32  forwarded rt operand (divisor / multiplier).
- busy  output  1  registered; high while an operation is in flight.
- stall  output  1  combinational: busy OR (start AND NOT cancel AND op in {0,1,2,3,6,7}).
- hi  output  32  registered HI.
- lo  output  32  registered LO.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - hi=0, lo=0, busy=0, internal counter=0.
  - Pending result discarded.
- Accept: start=1, cancel=0, busy=0 at edge E0.
  - start while busy=1 is ignored; the hazard unit never issues it.
  - start with cancel=1 is ignored entirely; no state change.
- mult/multu/div/divu/madd/maddu:
  - At E0, compute the result into a pending register.
  - Load the counter with N (MULT_CYCLES or DIV_CYCLES).
  - busy is high from after E0 through edge E_N: exactly N cycles.
  - Counter decrements each edge.
  - At E_N (counter 1->0), commit pending to hi/lo; busy falls on the same edge.
  - hi/lo keep their old values while busy=1.
- mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
- multu: unsigned 32x32 -> 64; same split.
- div: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned; lo=quotient, hi=remainder.
- Divide by zero (rt_data=0, div or divu):
  - busy sequence runs normally for DIV_CYCLES.
  - hi/lo unchanged at commit.
- mthi/mtlo: single-cycle, no busy. hi (or lo) <= rs_data at E0; the other register is unchanged.
- No cancel path once busy; an in-flight op always completes. The exception handler relies on this for HI/LO consistency.
- State machine: IDLE (counter=0) -> RUN on an accepted long op; RUN -> IDLE when the counter reaches 0.
- Back-to-back operation: a new start is accepted in the cycle busy reads 0, i.e. the cycle after E_N.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 6 (madd): {hi,lo} <= {hi,lo} + signed(rs_data)*signed(rt_data).
  - op 7 (maddu): same accumulate, unsigned product.
  - Both use MULT_CYCLES. The accumulator base is the hi/lo value at E0; 64-bit wrap-around.
- Undefined:
  - op 6/7 are no-ops: no busy, no hi/lo change.
  - stall excludes op 6/7.

Test Plan:
- mult with rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged during busy.
- div with rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu with rs=7, rt=0 -> busy 10 cycles; hi/lo unchanged.
- mthi rs=0x12345678, then next cycle mtlo rs=0x9ABCDEF0 -> hi/lo update on the accept edges; busy and stall never assert.
- Start mult with cancel=1 -> busy stays 0, hi/lo unchanged. Assert reset at cycle 3 of a div -> busy, hi and lo read 0 immediately (before the next edge).
- Back-to-back: multu 0xFFFFFFFF*0xFFFFFFFF, then restart in the first cycle busy=0 -> hi=0xFFFFFFFE, lo=0x00000001 after the first op; the second op is accepted with no lost cycle; start asserted during busy is ignored.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then madd rs=1, rt=1 -> after 5 cycles hi=1, lo=0. Without the macro: the same stimulus gives no busy and no change.
